// File: rtl/vga_pkg.sv
// Shared raster timing constants and coordinate type for the VGA front end.
// Defaults describe the 640x480@60 Hz mode on a 25 MHz pixel clock.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE_DEF  = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_VISIBLE_DEF  = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int PIPE_DELAY_DEF = 1;

  localparam int H_TOTAL_DEF =
    H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF =
    V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int HS_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int VS_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  // Idle value of the {hs, vs, blank} bundle: syncs high, not visible.
  localparam logic [2:0] SYNC_IDLE = 3'b110;

endpackage

// File: rtl/vga_if.sv
// Raster timing bundle from the timing generator to the drawing stages.
// The generator drives through master; consumers attach as slave.
interface vga_if;
  import vga_pkg::*;

  coord_t      DrawX;
  coord_t      DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        line_start;
  logic        frame_start;
  logic        vblank_start;
  logic [15:0] frame_count;
  logic        hs_d;
  logic        vs_d;
  logic        blank_d;

  modport master (
    output DrawX, DrawY, blank, hs, vs,
    output line_start, frame_start, vblank_start,
    output frame_count, hs_d, vs_d, blank_d
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs,
    input line_start, frame_start, vblank_start,
    input frame_count, hs_d, vs_d, blank_d
  );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async reset to a chosen idle value.
// DEPTH of zero collapses to a wire.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++)
          stage_q[i] <= RESET_VAL;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++)
          stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter with registered syncs, blank, strobes and frame counter.
// Decodes use next-state counters so they align with DrawX/DrawY.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
  input  logic  vga_clk,
  input  logic  reset_n,
  vga_if.master vga
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
      H_VISIBLE < 1 || V_VISIBLE < 1 ||
      H_FP < 0 || H_SYNC < 0 || H_BP < 0 ||
      V_FP < 0 || V_SYNC < 0 || V_BP < 0 ||
      HS_END > H_TOTAL || VS_END > V_TOTAL ||
      PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  // 11-bit compares so a window ending exactly at 1024 still decodes.
  localparam coord_t      H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t      V_LAST = coord_t'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_LO  = 11'(HS_START);
  localparam logic [10:0] HS_HI  = 11'(HS_END);
  localparam logic [10:0] VS_LO  = 11'(VS_START);
  localparam logic [10:0] VS_HI  = 11'(VS_END);

  coord_t      hc_q, hc_d;
  coord_t      vc_q, vc_d;
  logic        blank_q, blank_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic        vbs_q, vbs_d;
  logic [15:0] fc_q, fc_d;
  logic [10:0] hx, vx;
  logic [2:0]  dly;

  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
    hx      = {1'b0, hc_d};
    vx      = {1'b0, vc_d};
    blank_d = (hx < H_VIS) && (vx < V_VIS);
    hs_d    = !((hx >= HS_LO) && (hx < HS_HI));
    vs_d    = !((vx >= VS_LO) && (vx < VS_HI));
    ls_d    = (hc_d == '0);
    fs_d    = ls_d && (vc_d == '0);
    vbs_d   = ls_d && (vx == V_VIS);
    fc_d    = fs_d ? fc_q + 16'd1 : fc_q;
  end

  // Reset parks on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q    <= H_LAST;
      vc_q    <= V_LAST;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      vbs_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      vbs_q   <= vbs_d;
      fc_q    <= fc_d;
    end
  end

  vga_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_dly (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .d_i    ({hs_q, vs_q, blank_q}),
    .q_o    (dly)
  );

  assign vga.DrawX        = hc_q;
  assign vga.DrawY        = vc_q;
  assign vga.blank        = blank_q;
  assign vga.hs           = hs_q;
  assign vga.vs           = vs_q;
  assign vga.line_start   = ls_q;
  assign vga.frame_start  = fs_q;
  assign vga.vblank_start = vbs_q;
  assign vga.frame_count  = fc_q;
  assign {vga.hs_d, vga.vs_d, vga.blank_d} = dly;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-mode line checks, pipe-delay variants, async
// reset, and multi-frame checks on a shrunken raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  vga_if vif1 ();
  vga_if vif2 ();
  vga_if vif0 ();
  vga_if vifs ();

  vga_timing_gen #(.PIPE_DELAY(1)) u_p1 (
    .vga_clk (clk), .reset_n (rst_n), .vga (vif1));
  vga_timing_gen #(.PIPE_DELAY(2)) u_p2 (
    .vga_clk (clk), .reset_n (rst_n), .vga (vif2));
  vga_timing_gen #(.PIPE_DELAY(0)) u_p0 (
    .vga_clk (clk), .reset_n (rst_n), .vga (vif0));

  // 16 x 10 raster: hsync x=10..12, vsync y=7..8, 160 cycles/frame.
  vga_timing_gen #(
    .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_VISIBLE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .PIPE_DELAY (1)
  ) u_sm (
    .vga_clk (clk), .reset_n (rst_n), .vga (vifs));

  typedef struct {
    int cyc;
    int x, y, b, hs, ls, fs, fc;
    int bd1, hsd1, bd2, bd0;
  } vec_t;

  vec_t tbl [16];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int lo_n, lo_first, lo_last, sh_bad;
  int hb0, hb1, hh0, hh1;
  int sm_err, fs_n, last_fs, gap_bad, vbs_n, vs_lo;
  int ex, ey;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"},   int'(vif1.DrawX), 799);
    chk({tag, "_y"},   int'(vif1.DrawY), 524);
    chk({tag, "_b"},   int'(vif1.blank), 0);
    chk({tag, "_hs"},  int'(vif1.hs), 1);
    chk({tag, "_vs"},  int'(vif1.vs), 1);
    chk({tag, "_ls"},  int'(vif1.line_start), 0);
    chk({tag, "_fs"},  int'(vif1.frame_start), 0);
    chk({tag, "_vbs"}, int'(vif1.vblank_start), 0);
    chk({tag, "_fc"},  int'(vif1.frame_count), 0);
    chk({tag, "_bd1"}, int'(vif1.blank_d), 0);
    chk({tag, "_bd2"}, int'(vif2.blank_d), 0);
    chk({tag, "_hd2"}, int'(vif2.hs_d), 1);
    chk({tag, "_vd2"}, int'(vif2.vs_d), 1);
    chk({tag, "_sfc"}, int'(vifs.frame_count), 0);
  endtask

  initial begin
    tbl[0]  = '{1,   0,   0, 1, 1, 1, 1, 1, 0, 1, 0, 1};
    tbl[1]  = '{2,   1,   0, 1, 1, 0, 0, 1, 1, 1, 0, 1};
    tbl[2]  = '{3,   2,   0, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    tbl[3]  = '{640, 639, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    tbl[4]  = '{641, 640, 0, 0, 1, 0, 0, 1, 1, 1, 1, 0};
    tbl[5]  = '{642, 641, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0};
    tbl[6]  = '{643, 642, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    tbl[7]  = '{657, 656, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    tbl[8]  = '{658, 657, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[9]  = '{752, 751, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{753, 752, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{754, 753, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    tbl[12] = '{800, 799, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    tbl[13] = '{801, 0,   1, 1, 1, 1, 0, 1, 0, 1, 0, 1};
    tbl[14] = '{802, 1,   1, 1, 1, 0, 0, 1, 1, 1, 0, 1};
    tbl[15] = '{803, 2,   1, 1, 1, 0, 0, 1, 1, 1, 1, 1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");

    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    for (int i = 0; i < 16; i++) begin
      while (cyc < tbl[i].cyc) step();
      chk($sformatf("x@%0d", cyc),   int'(vif1.DrawX), tbl[i].x);
      chk($sformatf("y@%0d", cyc),   int'(vif1.DrawY), tbl[i].y);
      chk($sformatf("b@%0d", cyc),   int'(vif1.blank), tbl[i].b);
      chk($sformatf("hs@%0d", cyc),  int'(vif1.hs), tbl[i].hs);
      chk($sformatf("vs@%0d", cyc),  int'(vif1.vs), 1);
      chk($sformatf("ls@%0d", cyc),  int'(vif1.line_start), tbl[i].ls);
      chk($sformatf("fs@%0d", cyc),  int'(vif1.frame_start), tbl[i].fs);
      chk($sformatf("vbs@%0d", cyc), int'(vif1.vblank_start), 0);
      chk($sformatf("fc@%0d", cyc),  int'(vif1.frame_count), tbl[i].fc);
      chk($sformatf("bd1@%0d", cyc), int'(vif1.blank_d), tbl[i].bd1);
      chk($sformatf("hd1@%0d", cyc), int'(vif1.hs_d), tbl[i].hsd1);
      chk($sformatf("bd2@%0d", cyc), int'(vif2.blank_d), tbl[i].bd2);
      chk($sformatf("bd0@%0d", cyc), int'(vif0.blank_d), tbl[i].bd0);
    end

    // Rest of line 1: hsync window and delay-line tracking.
    lo_n = 0; lo_first = -1; lo_last = -1; sh_bad = 0;
    hb0 = 1; hb1 = 1; hh0 = 1; hh1 = 1;
    while (cyc < 1600) begin
      step();
      if (vif1.hs === 1'b0) begin
        lo_n++;
        if (lo_first < 0) lo_first = int'(vif1.DrawX);
        lo_last = int'(vif1.DrawX);
      end
      if (int'(vif2.blank_d) !== hb1) sh_bad++;
      if (int'(vif2.hs_d) !== hh1) sh_bad++;
      if (vif0.blank_d !== vif0.blank) sh_bad++;
      if (vif0.hs_d !== vif0.hs) sh_bad++;
      if (vif0.vs_d !== vif0.vs) sh_bad++;
      hb1 = hb0; hb0 = int'(vif2.blank);
      hh1 = hh0; hh0 = int'(vif2.hs);
    end
    chk("hs_low_cycles", lo_n, 96);
    chk("hs_low_first", lo_first, 656);
    chk("hs_low_last", lo_last, 751);
    chk("dly_shift_err", sh_bad, 0);
    chk("end_l1_x", int'(vif1.DrawX), 799);
    chk("end_l1_y", int'(vif1.DrawY), 1);

    while (cyc < 1901) step();
    chk("mid_x", int'(vif1.DrawX), 300);
    chk("mid_y", int'(vif1.DrawY), 2);

    // Mid-cycle assertion: no clock edge before the check.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    repeat (5) @(posedge clk);
    #1;
    chk_reset("hold");

    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    step();
    chk("rel_x", int'(vif1.DrawX), 0);
    chk("rel_y", int'(vif1.DrawY), 0);
    chk("rel_fs", int'(vif1.frame_start), 1);
    chk("rel_ls", int'(vif1.line_start), 1);
    chk("rel_b", int'(vif1.blank), 1);
    chk("rel_fc", int'(vif1.frame_count), 1);

    // Three full frames of the small raster.
    sm_err = 0; fs_n = 0; last_fs = -1;
    gap_bad = 0; vbs_n = 0; vs_lo = 0;
    for (int k = 0; k < 480; k++) begin
      if (k > 0) step();
      ex = (cyc - 1) % 16;
      ey = ((cyc - 1) / 16) % 10;
      if (int'(vifs.DrawX) !== ex) sm_err++;
      if (int'(vifs.DrawY) !== ey) sm_err++;
      if (vifs.blank !== (ex < 8 && ey < 6)) sm_err++;
      if (vifs.hs !== !(ex >= 10 && ex < 13)) sm_err++;
      if (vifs.vs !== !(ey >= 7 && ey < 9)) sm_err++;
      if (vifs.line_start !== (ex == 0)) sm_err++;
      if (vifs.frame_start !== (ex == 0 && ey == 0)) sm_err++;
      if (vifs.vblank_start === 1'b1) begin
        vbs_n++;
        if (ex != 0 || ey != 6) sm_err++;
      end
      if (vifs.vs === 1'b0) vs_lo++;
      if (vifs.frame_start === 1'b1) begin
        fs_n++;
        if (last_fs >= 0 && cyc - last_fs != 160) gap_bad++;
        last_fs = cyc;
      end
    end
    chk("sm_raster_err", sm_err, 0);
    chk("sm_fs_count", fs_n, 3);
    chk("sm_fs_gap_err", gap_bad, 0);
    chk("sm_vbs_count", vbs_n, 3);
    chk("sm_vs_low", vs_lo, 96);
    chk("sm_fc_end3", int'(vifs.frame_count), 3);

    step();
    chk("sm_f4_fs", int'(vifs.frame_start), 1);
    chk("sm_f4_fc", int'(vifs.frame_count), 4);
    chk("sm_f4_x", int'(vifs.DrawX), 0);
    chk("sm_f4_y", int'(vifs.DrawY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
